// File: rtl/unit_arbiter_if.sv
// Bus between the thread array, the execution-unit arbiter and the unit mux.
// The slave side is the arbiter; the master side is the thread array plus
// the unit mux, which supplies unit_out.
interface unit_arbiter_if #(
  parameter int N_THREADS = 4,
  parameter int WORD_W    = 32,
  parameter int SEL_W     = 2
);
  // Thread request side
  logic [N_THREADS-1:0]                   req;
  logic [N_THREADS-1:0][SEL_W-1:0]        req_sel;
  logic [N_THREADS-1:0][WORD_W-1:0]       req_ctrl;
  logic [N_THREADS-1:0][1:0][WORD_W-1:0]  req_in;
  logic [N_THREADS-1:0]                   gnt;
  logic [N_THREADS-1:0]                   resp_valid;
  logic [WORD_W-1:0]                      resp_data;

  // Shared unit side
  logic [SEL_W-1:0]                       unit_sel;
  logic [WORD_W-1:0]                      unit_ctrl;
  logic [1:0][WORD_W-1:0]                 unit_in;
  logic [WORD_W-1:0]                      unit_out;

  modport slave (
    input  req, req_sel, req_ctrl, req_in, unit_out,
    output gnt, resp_valid, resp_data, unit_sel, unit_ctrl, unit_in
  );

  modport master (
    output req, req_sel, req_ctrl, req_in, unit_out,
    input  gnt, resp_valid, resp_data, unit_sel, unit_ctrl, unit_in
  );
endinterface

// File: rtl/unit_arbiter.sv
// Round-robin arbiter sharing one execution-unit port among N_THREADS
// threads. Grant in cycle t, unit driven in t+1, result returned in t+2.
// Unit select code 0 means "no unit".
module unit_arbiter #(
  parameter int N_THREADS = 4,
  parameter int ID_W      = (N_THREADS > 1) ? $clog2(N_THREADS) : 1,
  parameter int WORD_W    = 32,
  parameter int SEL_W     = 2
) (
  input  logic          clk,
  input  logic          rst,
  unit_arbiter_if.slave bus
);

  // Thread index base+off, wrapped modulo N_THREADS (off < N_THREADS).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_THREADS) begin
      sum = sum - N_THREADS;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  // State
  logic [ID_W-1:0]        ptr_q,      ptr_d;
  logic [N_THREADS-1:0]   busy_q,     busy_d;
  logic                   iss_v_q,    iss_v_d;
  logic [ID_W-1:0]        iss_id_q,   iss_id_d;
  logic [SEL_W-1:0]       iss_sel_q,  iss_sel_d;
  logic [WORD_W-1:0]      iss_ctrl_q, iss_ctrl_d;
  logic [1:0][WORD_W-1:0] iss_in_q,   iss_in_d;
  logic                   rsp_v_q,    rsp_v_d;
  logic [ID_W-1:0]        rsp_id_q,   rsp_id_d;
  logic [WORD_W-1:0]      rsp_data_q, rsp_data_d;

  // Combinational
  logic [N_THREADS-1:0]   resp_valid_s;
  logic [N_THREADS-1:0]   elig_s;
  logic [N_THREADS-1:0]   gnt_s;
  logic                   found_s;
  logic [ID_W-1:0]        gnt_id_s;
  logic [ID_W-1:0]        cand_s;

  // Decode the response register into a one-hot per-thread strobe.
  always_comb begin
    resp_valid_s = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      resp_valid_s[i] = rsp_v_q & (rsp_id_q == ID_W'(i));
    end
  end

  // Round-robin search from ptr; a thread in its response cycle is re-grantable.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    elig_s   = bus.req & (~busy_q | resp_valid_s) & {N_THREADS{rst}};
    found_s  = 1'b0;
    gnt_id_s = '0;
    cand_s   = '0;
    for (int k = 0; k < N_THREADS; k++) begin
      cand_s = wrap_idx(ptr_q, k);
      if (!found_s && elig_s[cand_s]) begin
        found_s  = 1'b1;
        gnt_id_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
    gnt_s           = '0;
    gnt_s[gnt_id_s] = found_s;
  end

  // Next-state: pointer advance, busy tracking, issue and response stages.
  always_comb begin
    if (found_s) begin
      ptr_d = (gnt_id_s == ID_W'(N_THREADS - 1)) ? '0 : (gnt_id_s + ID_W'(1));
    end else begin
      ptr_d = ptr_q;
    end

    // A re-grant in the response cycle keeps the thread busy.
    busy_d = (busy_q & ~resp_valid_s) | gnt_s;

    // Idle issue slots load zeros so the unit bus reads as "none".
    iss_v_d  = found_s;
    iss_id_d = gnt_id_s;
    if (found_s) begin
      iss_sel_d  = bus.req_sel[gnt_id_s];
      iss_ctrl_d = bus.req_ctrl[gnt_id_s];
      iss_in_d   = bus.req_in[gnt_id_s];
    end else begin
      iss_sel_d  = '0;
      iss_ctrl_d = '0;
      iss_in_d   = '0;
    end

    // unit_out is only meaningful during an issue cycle.
    rsp_v_d  = iss_v_q;
    rsp_id_d = iss_id_q;
    if (iss_v_q) begin
      rsp_data_d = bus.unit_out;
    end else begin
      rsp_data_d = '0;
    end
  end

  // State registers with synchronous active-low reset; reset drops in-flight ops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      busy_q     <= '0;
      iss_v_q    <= 1'b0;
      iss_id_q   <= '0;
      iss_sel_q  <= '0;
      iss_ctrl_q <= '0;
      iss_in_q   <= '0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      iss_v_q    <= iss_v_d;
      iss_id_q   <= iss_id_d;
      iss_sel_q  <= iss_sel_d;
      iss_ctrl_q <= iss_ctrl_d;
      iss_in_q   <= iss_in_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.gnt        = gnt_s;
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_data  = rsp_data_q;
  assign bus.unit_sel   = iss_sel_q;
  assign bus.unit_ctrl  = iss_ctrl_q;
  assign bus.unit_in    = iss_in_q;

endmodule

// File: tb/tb_unit_arbiter.sv
// Directed bench for unit_arbiter: reset, single op, round-robin, busy
// masking, reset mid-flight, pointer wrap after idle.
module tb_unit_arbiter;

  localparam int N = 4;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_RAM = 2'd2;

  // Expected round-robin pattern after reset release, all threads requesting.
  localparam logic [3:0] RR_GNT [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  localparam logic [3:0] RR_RV  [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam int         RR_ID  [7] = '{0, 1, 2, 3, 0, 1, 2};

  // Expected pattern for thread 1 requesting alone (req dropped from step 5).
  localparam logic [3:0] BM_GNT [8] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  localparam logic [3:0] BM_RV  [8] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  unit_arbiter_if #(.N_THREADS(N), .WORD_W(32), .SEL_W(2)) bus ();

  unit_arbiter #(.N_THREADS(N), .WORD_W(32), .SEL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Unit model: ALU ctrl 0 = add, otherwise subtract; RAM returns a tagged operand 0.
  always_comb begin
    case (bus.unit_sel)
      SEL_ALU: bus.unit_out = (bus.unit_ctrl == 32'd0) ? (bus.unit_in[0] + bus.unit_in[1])
                                                       : (bus.unit_in[0] - bus.unit_in[1]);
      SEL_RAM: bus.unit_out = 32'hA5A5_0000 | bus.unit_in[0];
      default: bus.unit_out = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int i, input logic [1:0] sel, input logic [31:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_sel[i]   = sel;
    bus.req_ctrl[i]  = ctrl;
    bus.req_in[i][0] = a;
    bus.req_in[i][1] = b;
  endtask

  initial begin
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      set_thr(i, SEL_ALU, 32'd0, 32'(i + 1), 32'(10 * (i + 1)));
    end

    // Reset held 3 cycles with every thread requesting
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      chk("rst_gnt",        64'(bus.gnt),        64'h0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      chk("rst_resp_data",  64'(bus.resp_data),  64'h0);
      chk("rst_unit_sel",   64'(bus.unit_sel),   64'h0);
      chk("rst_unit_ctrl",  64'(bus.unit_ctrl),  64'h0);
      chk("rst_unit_in",    64'(bus.unit_in),    64'h0);
    end

    // Release reset; round-robin with all threads requesting
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (c == 0) rst = 1'b1;
      #1;
      chk("rr_gnt",        64'(bus.gnt),        64'(RR_GNT[c]));
      chk("rr_resp_valid", 64'(bus.resp_valid), 64'(RR_RV[c]));
      if (RR_RV[c] != 4'b0000) begin
        chk("rr_resp_data", 64'(bus.resp_data), 64'(11 * (RR_ID[c - 2] + 1)));
      end
      if (c > 0) begin
        chk("rr_unit_in0", 64'(bus.unit_in[0]), 64'(RR_ID[c - 1] + 1));
      end
    end

    // Drain outstanding ops of threads 1 and 2
    cyc(); bus.req = 4'b0000; #1;
    chk("drain_gnt",   64'(bus.gnt),        64'h0);
    chk("drain_rv1",   64'(bus.resp_valid), 64'(4'b0010));
    chk("drain_rd1",   64'(bus.resp_data),  64'd22);
    cyc(); #1;
    chk("drain_rv2",   64'(bus.resp_valid), 64'(4'b0100));
    chk("drain_rd2",   64'(bus.resp_data),  64'd33);
    cyc(); #1;
    chk("drain_rv_idle", 64'(bus.resp_valid), 64'h0);

    // Single op: thread 2 ADD 5+7
    cyc(); set_thr(2, SEL_ALU, 32'd0, 32'd5, 32'd7); bus.req = 4'b0100; #1;
    chk("single_gnt", 64'(bus.gnt), 64'(4'b0100));
    cyc(); bus.req = 4'b0000; #1;
    chk("single_gnt_off",  64'(bus.gnt),          64'h0);
    chk("single_unit_sel", 64'(bus.unit_sel),     64'(SEL_ALU));
    chk("single_unit_ctl", 64'(bus.unit_ctrl),    64'h0);
    chk("single_unit_in0", 64'(bus.unit_in[0]),   64'd5);
    chk("single_unit_in1", 64'(bus.unit_in[1]),   64'd7);
    chk("single_rv_early", 64'(bus.resp_valid),   64'h0);
    cyc(); #1;
    chk("single_rv",       64'(bus.resp_valid),   64'(4'b0100));
    chk("single_rd",       64'(bus.resp_data),    64'd12);

    // Busy masking: thread 1 alone, SUB 50-8
    set_thr(1, SEL_ALU, 32'd1, 32'd50, 32'd8);
    for (int k = 0; k < 8; k++) begin
      cyc();
      bus.req = (k < 5) ? 4'b0010 : 4'b0000;
      #1;
      chk("busy_gnt", 64'(bus.gnt),        64'(BM_GNT[k]));
      chk("busy_rv",  64'(bus.resp_valid), 64'(BM_RV[k]));
      if (BM_RV[k] != 4'b0000) begin
        chk("busy_rd", 64'(bus.resp_data), 64'd42);
      end
    end

    // Reset mid-flight: grant thread 3, reset in the issue cycle
    set_thr(3, SEL_ALU, 32'd0, 32'd100, 32'd23);
    cyc(); bus.req = 4'b1000; #1;
    chk("mid_gnt",       64'(bus.gnt),        64'(4'b1000));
    cyc(); bus.req = 4'b0000; rst = 1'b0; #1;
    chk("mid_issue_sel", 64'(bus.unit_sel),   64'(SEL_ALU));
    chk("mid_rv_issue",  64'(bus.resp_valid), 64'h0);
    cyc(); rst = 1'b1; bus.req = 4'b1000; #1;
    chk("mid_rv_killed", 64'(bus.resp_valid), 64'h0);
    chk("mid_unit_sel0", 64'(bus.unit_sel),   64'h0);
    chk("mid_busy_clr",  64'(bus.gnt),        64'(4'b1000));
    cyc(); bus.req = 4'b0000; #1;
    chk("mid_rv_none",   64'(bus.resp_valid), 64'h0);
    chk("mid_unit_in1",  64'(bus.unit_in[1]), 64'd23);
    cyc(); #1;
    chk("mid_rv_new",    64'(bus.resp_valid), 64'(4'b1000));
    chk("mid_rd_new",    64'(bus.resp_data),  64'd123);

    // Idle after thread 3 grant (pointer wrapped to 0)
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("idle_gnt", 64'(bus.gnt),        64'h0);
      chk("idle_rv",  64'(bus.resp_valid), 64'h0);
    end

    // Threads 0 (RAM) and 2 (SUB 9-4) request together
    set_thr(0, SEL_RAM, 32'd3, 32'h11, 32'd0);
    set_thr(2, SEL_ALU, 32'd1, 32'd9, 32'd4);
    cyc(); bus.req = 4'b0101; #1;
    chk("wrap_gnt0",     64'(bus.gnt),        64'(4'b0001));
    cyc(); #1;
    chk("wrap_gnt2",     64'(bus.gnt),        64'(4'b0100));
    chk("wrap_unit_sel", 64'(bus.unit_sel),   64'(SEL_RAM));
    chk("wrap_unit_in0", 64'(bus.unit_in[0]), 64'h11);
    cyc(); bus.req = 4'b0000; #1;
    chk("wrap_rv0",      64'(bus.resp_valid), 64'(4'b0001));
    chk("wrap_rd0",      64'(bus.resp_data),  64'hA5A5_0011);
    chk("wrap_unit_sel2", 64'(bus.unit_sel),  64'(SEL_ALU));
    cyc(); #1;
    chk("wrap_rv2",      64'(bus.resp_valid), 64'(4'b0100));
    chk("wrap_rd2",      64'(bus.resp_data),  64'd5);
    cyc(); #1;
    chk("final_rv",      64'(bus.resp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unit_arbiter.md
# unit_arbiter

Shares one ALU/RAM execution-unit port among `N_THREADS` thread blocks. Each thread posts a unit request (select, control word, two operands); the arbiter grants one per cycle round-robin, registers it, drives the shared unit bus for one cycle, captures `unit_out`, and returns it to the requesting thread. It sits between the thread array and the unit mux (ALU, RAM).

## Interface

**Parameters**
- `N_THREADS`, default 4: number of thread request ports; ≥1.
- `ID_W`, default `$clog2(N_THREADS)` (min 1): width of the thread index.

**Ports**
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous and active-low.
- `req`, input, N_THREADS: per-thread request valid; held until granted.
- `req_sel`, input, N_THREADS x unit_sel_t: requested unit.
- `req_ctrl`, input, N_THREADS x word_t: unit control word.
- `req_in`, input, N_THREADS x 2 x word_t: operands 0 and 1.
- `gnt`, output, N_THREADS: one-hot grant, combinational, same cycle as accept.
- `resp_valid`, output, N_THREADS: one-hot, 1-cycle result strobe.
- `resp_data`, output, word_t: result, valid where `resp_valid` is set.
- `unit_sel`, output, unit_sel_t: to unit mux.
- `unit_ctrl`, output, word_t: to unit mux.
- `unit_in`, output, 2 x word_t: to unit mux.
- `unit_out`, input, word_t: unit result, combinational off `unit_*`.

## Operation

**State**
- `ptr` (ID_W): round-robin priority pointer.
- `busy` (N_THREADS): thread has an op in flight.
- Issue register: `iss_v`, `iss_id`, `iss_sel`, `iss_ctrl`, `iss_in[1:0]`.
- Response register: `rsp_v`, `rsp_id`, `rsp_data`.

**Arbitration (combinational)**
- Eligible: `req[i] & (~busy[i] | resp_valid[i])`.
- Search eligible threads starting at `ptr`, wrapping modulo N_THREADS. The first hit is granted; `gnt` is one-hot or zero.
- On a grant to `i`: `ptr <= (i+1) mod N_THREADS`. With no grant, `ptr` holds.

**Pipeline**
- Accept: the granted request loads the issue register and sets `busy[i]`.
- With no grant, `iss_v <= 0`.
- Issue: when `iss_v=1`, `unit_*` are driven from the issue register. When `iss_v=0`, `unit_sel=0` (none), `unit_ctrl=0`, `unit_in=0`.
- Response: `rsp_v <= iss_v`, `rsp_id <= iss_id`, `rsp_data <= unit_out`.
- Output: `resp_valid[i] = rsp_v & (rsp_id==i)`, `resp_data = rsp_data`.
- `busy[i]` clears at the edge ending a cycle with `resp_valid[i]=1`, unless that thread is re-granted in the same cycle; then it stays set.

**Reset**
- Effect: `ptr=0`, `busy=0`, `iss_v=0`, `rsp_v=0`, all data registers 0.
- Outputs during and after reset: `gnt=0`, `resp_valid=0`, `resp_data=0`, `unit_sel=0`, `unit_ctrl=0`, `unit_in={0,0}`.
- Reset mid-operation discards in-flight ops; no response is ever produced for them.

## Timing

- Grant in cycle t: units driven in t+1, `resp_valid` and `resp_data` in t+2. Latency is 2 cycles from grant.
- Aggregate throughput: one op per cycle.
- Per-thread throughput: one op per 2 cycles, since the thread is re-grantable in its response cycle.
- `req` asserted while busy (not in its response cycle) is ignored; no grant, no error.
- `req` dropped before grant: the request is withdrawn and nothing is recorded.
- Single requester: it wins regardless of `ptr`.
- Pointer wrap: a grant to thread N_THREADS-1 sets `ptr=0`.
- `unit_out` is sampled only at the end of the issue cycle; its value in other cycles is don't-care.

## Test plan

1. **Reset.** Hold `rst=0` 3 cycles with all `req=1`. Required: all outputs 0 and `gnt=0`. Release; first grant goes to thread 0.
2. **Single op.** Thread 2 requests ALU ADD with `in={5,7}`, unit model returns the sum. Required: `gnt[2]` in cycle t; `unit_in={5,7}` in t+1; `resp_valid=4'b0100` and `resp_data=12` in t+2.
3. **Round-robin.** All 4 threads request continuously. Required grant order: 0,1,2,3,0,1,… with one grant per cycle and each response 2 cycles after its grant.
4. **Busy masking.** Thread 1 requests continuously, alone. Required: grants in t, t+2, t+4; `resp_valid[1]` in t+2, t+4, t+6.
5. **Reset mid-flight.** Grant thread 3, then assert `rst=0` in t+1. Required: no `resp_valid` ever appears for that op, and `busy[3]` is cleared.
6. **Wrap and idle.** Grant thread 3, idle 5 cycles, then threads 0 and 2 request together. Required: thread 0 is granted first, then thread 2.
